updown_count_ctrl: RTL and testbench

//  Sequencer for the WIDTH-bit loadable up/down counter. It accepts a

---
 rtl/updown_count_ctrl_if.sv | 21 ++
 rtl/updown_count_ctrl.sv | 83 ++++++++
 tb/tb_updown_count_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/updown_count_ctrl_if.sv
// Command channel into the up/down counter sequencer: valid/ready handshake
// carrying the start value, the target value and the count direction.
interface updown_count_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_end;
    logic             cmd_up;

    modport master (
        output cmd_valid, cmd_start, cmd_end, cmd_up,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_end, cmd_up,
        output cmd_ready
    );
endinterface

// File: rtl/updown_count_ctrl.sv
// Sequencer for a loadable up/down counter: loads start, steps once every DIV
// cycles toward end (wrapping), then pulses done; abort cancels a command.
module updown_count_ctrl #(
    parameter int WIDTH = 3,
    parameter int DIV   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    updown_count_ctrl_if.slave        cmd,
    input  logic                      pause,
    input  logic                      abort,
    output logic                      cnt_load,
    output logic [WIDTH-1:0]          cnt_data,
    output logic                      cnt_en,
    output logic                      cnt_up_down,
    input  logic [WIDTH-1:0]          cnt_value,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted
);
    localparam int              PW         = $clog2(DIV + 1);
    localparam logic [PW-1:0]   PRE_RELOAD = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] start_q, end_q;
    logic             up_q;
    logic [PW-1:0]    presc;
    logic             at_end;

    assign at_end = (cnt_value == end_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // abort outranks the end check, which outranks pause and the prescaler
    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        case (state)
            IDLE: if (cmd.cmd_valid) state_nxt = LOAD;
            LOAD: state_nxt = abort ? IDLE : RUN;
            RUN: begin
                if (abort)                       state_nxt = IDLE;
                else if (at_end)                 state_nxt = DONE;
                else if (!pause && presc == '0)  cnt_en = 1'b1;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= '0;
            end_q   <= '0;
            up_q    <= 1'b0;
            presc   <= '0;
            aborted <= 1'b0;
        end else begin
            aborted <= abort && (state == LOAD || state == RUN);
            if (state == IDLE && cmd.cmd_valid) begin
                start_q <= cmd.cmd_start;
                end_q   <= cmd.cmd_end;
                up_q    <= cmd.cmd_up;
            end
            if (state == LOAD)
                presc <= PRE_RELOAD;
            else if (state == RUN && !abort && !at_end && !pause)
                presc <= (presc == '0) ? PRE_RELOAD : presc - 1'b1;
        end
    end

    assign cmd.cmd_ready = (state == IDLE);
    assign cnt_load      = (state == LOAD);
    assign cnt_data      = cnt_load ? start_q : '0;
    assign cnt_up_down   = (state == RUN) && up_q;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
endmodule

// File: tb/tb_updown_count_ctrl.sv
// Bench for updown_count_ctrl: a DIV=1 and a DIV=4 instance, each driving a
// behavioural counter; expected step count/latency/final value per command.
module tb_updown_count_ctrl;
    localparam int W = 3;
    typedef logic [W-1:0] val_t;
    typedef struct { val_t s; val_t e; logic up; int steps; int lat; val_t fin; } vec_t;
    typedef struct { int steps; int lat; val_t fin; } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic sel, valid, up, pause, abort;
    val_t st, tgt;
    int   total = 0, bad = 0;
    exp_t exp_q[$];

    updown_count_ctrl_if #(.WIDTH(W)) ia ();
    updown_count_ctrl_if #(.WIDTH(W)) ib ();

    logic a_load, a_en, a_ud, a_busy, a_done, a_ab;
    logic b_load, b_en, b_ud, b_busy, b_done, b_ab;
    val_t a_data, a_value, b_data, b_value;

    assign ia.cmd_valid = valid & ~sel;
    assign ib.cmd_valid = valid & sel;
    assign ia.cmd_start = st;
    assign ib.cmd_start = st;
    assign ia.cmd_end   = tgt;
    assign ib.cmd_end   = tgt;
    assign ia.cmd_up    = up;
    assign ib.cmd_up    = up;

    updown_count_ctrl #(.WIDTH(W), .DIV(1)) dut_a (
        .clk(clk), .reset(reset), .cmd(ia.slave),
        .pause(pause & ~sel), .abort(abort & ~sel),
        .cnt_load(a_load), .cnt_data(a_data), .cnt_en(a_en), .cnt_up_down(a_ud),
        .cnt_value(a_value), .busy(a_busy), .done(a_done), .aborted(a_ab)
    );

    updown_count_ctrl #(.WIDTH(W), .DIV(4)) dut_b (
        .clk(clk), .reset(reset), .cmd(ib.slave),
        .pause(pause & sel), .abort(abort & sel),
        .cnt_load(b_load), .cnt_data(b_data), .cnt_en(b_en), .cnt_up_down(b_ud),
        .cnt_value(b_value), .busy(b_busy), .done(b_done), .aborted(b_ab)
    );

    // behavioural counters: load wins over enable, new value visible next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       a_value <= '0;
        else if (a_load) a_value <= a_data;
        else if (a_en)   a_value <= a_ud ? a_value + 1'b1 : a_value - 1'b1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       b_value <= '0;
        else if (b_load) b_value <= b_data;
        else if (b_en)   b_value <= b_ud ? b_value + 1'b1 : b_value - 1'b1;
    end

    logic m_ready, m_load, m_en, m_ud, m_busy, m_done, m_ab;
    val_t m_data, m_value;
    assign m_ready = sel ? ib.cmd_ready : ia.cmd_ready;
    assign m_load  = sel ? b_load  : a_load;
    assign m_en    = sel ? b_en    : a_en;
    assign m_ud    = sel ? b_ud    : a_ud;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_ab    = sel ? b_ab    : a_ab;
    assign m_data  = sel ? b_data  : a_data;
    assign m_value = sel ? b_value : a_value;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns at the falling edge inside the LOAD cycle (cycle 0).
    task automatic issue(input val_t s, input val_t e, input logic u);
        for (int k = 0; k < 20 && !m_ready; k++) @(negedge clk);
        st = s; tgt = e; up = u; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input val_t s, input val_t e, input logic u,
                           input int steps, input int lat, input val_t fin,
                           input int pf, input int pl);
        exp_t ex, got;
        logic dir_ok;
        ex.steps = steps; ex.lat = lat; ex.fin = fin;
        exp_q.push_back(ex);
        issue(s, e, u);
        got.steps = 0; got.lat = -1; got.fin = '0; dir_ok = 1'b1;
        for (int c = 0; c < 200; c++) begin
            pause = (c >= pf) && (c < pf + pl);
            #1;
            if (c == 0) chk({tag, "_load"}, {m_load, m_data}, {1'b1, s});
            if (m_en) got.steps++;
            if (c > 0 && m_busy && !m_done && m_ud !== u) dir_ok = 1'b0;
            if (m_done) begin got.lat = c; got.fin = m_value; break; end
            @(negedge clk);
        end
        pause = 1'b0;
        ex = exp_q.pop_front();
        chk({tag, "_steps"}, got.steps, ex.steps);
        chk({tag, "_latency"}, got.lat, ex.lat);
        chk({tag, "_final"}, got.fin, ex.fin);
        chk({tag, "_dir"}, dir_ok, 1'b1);
        @(negedge clk); #1;
        chk({tag, "_ready_after"}, {m_ready, m_busy, m_done}, 3'b100);
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{s: 2, e: 5, up: 1, steps: 3, lat: 5, fin: 5};
        vecs[1] = '{s: 6, e: 1, up: 1, steps: 3, lat: 5, fin: 1};
        vecs[2] = '{s: 1, e: 6, up: 0, steps: 3, lat: 5, fin: 6};
        vecs[3] = '{s: 4, e: 4, up: 1, steps: 0, lat: 2, fin: 4};
        vecs[4] = '{s: 0, e: 7, up: 1, steps: 7, lat: 9, fin: 7};
        vecs[5] = '{s: 7, e: 0, up: 1, steps: 1, lat: 3, fin: 0};
        vecs[6] = '{s: 0, e: 7, up: 0, steps: 1, lat: 3, fin: 7};
        vecs[7] = '{s: 3, e: 2, up: 1, steps: 7, lat: 9, fin: 2};

        sel = 1'b0; valid = 1'b1; up = 1'b1; pause = 1'b0; abort = 1'b0;
        st = 3'd5; tgt = 3'd6; reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", {m_load, m_en, m_ud, m_busy, m_done, m_ab, m_ready, m_data},
            {6'b0, 1'b1, 3'b0});
        valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_release_idle", {m_ready, m_busy}, 2'b10);

        for (int i = 0; i < 8; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].up,
                    vecs[i].steps, vecs[i].lat, vecs[i].fin, 0, 0);

        for (int i = 0; i < 6; i++) begin
            val_t s, e, d;
            logic u;
            s = val_t'($urandom_range(0, 7));
            e = val_t'($urandom_range(0, 7));
            u = 1'($urandom_range(0, 1));
            d = u ? e - s : s - e;
            run_cmd($sformatf("rnd%0d", i), s, e, u, int'(d), int'(d) + 2, e, 0, 0);
        end

        // abort in IDLE has no effect
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("idle_abort", {m_ab, m_busy, m_ready}, 3'b001);

        // abort mid-RUN at value 3 of 0->7
        issue(3'd0, 3'd7, 1'b1);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (m_value == 3'd3 && !m_load) break;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_pulse", {m_ab, m_done, m_busy, m_value}, {3'b100, 3'd3});
        @(negedge clk); #1;
        chk("abort_after", {m_ab, m_done, m_value}, {2'b00, 3'd3});
        run_cmd("post_abort", 3'd5, 3'd6, 1'b1, 1, 3, 3'd6, 0, 0);

        // asynchronous reset mid-RUN, with a handshake held during reset
        issue(3'd0, 3'd7, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrun_reset", {m_load, m_en, m_ud, m_busy, m_done, m_ab, m_ready, m_data},
            {6'b0, 1'b1, 3'b0});
        valid = 1'b1;
        @(negedge clk); #1;
        chk("reset_ignores_cmd", {m_busy, m_ready}, 2'b01);
        valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_cmd("after_reset", 3'd1, 3'd3, 1'b1, 2, 4, 3'd3, 0, 0);

        // DIV=4 instance: plain run, pause of 3 cycles, and a downward run
        sel = 1'b1;
        run_cmd("div4", 3'd0, 3'd2, 1'b1, 2, 10, 3'd2, 0, 0);
        run_cmd("div4_pause", 3'd0, 3'd2, 1'b1, 2, 13, 3'd2, 2, 3);
        run_cmd("div4_down", 3'd1, 3'd7, 1'b0, 2, 10, 3'd7, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
